seq_imul: RTL and testbench

- Parametrised sequential integer multiplier: radix-2 shift-and-add, one partial product per clock.
- Successor to the 4x4 combinational array multiplier; trades latency for area, which matters at large WIDTH.
- Adds a runtime signed/unsigned mode and a start/busy/done handshake, so a controller or datapath FSM can issue multiplies.

---
 rtl/seq_imul.sv | 106 ++++++++++
 tb/tb_seq_imul.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_imul.sv
// seq_imul: radix-2 shift-and-add multiplier, signed/unsigned mode chosen per operation.
// Latency WIDTH+2 cycles from start edge to oDone; iStart is ignored while busy.
module seq_imul #(
   parameter int WIDTH = 4
) (
   input  logic               Clock,
   input  logic               Reset_n,
   input  logic               iStart,
   input  logic               iSigned,
   input  logic [WIDTH-1:0]   iA,
   input  logic [WIDTH-1:0]   iB,
   output logic               oBusy,
   output logic               oDone,
   output logic [2*WIDTH-1:0] oResult
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, CALC, SIGN} state_t;

   state_t             state_q, state_d;
   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [2*WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               neg_q, neg_d;
   logic               done_q, done_d;
   logic               busy;

   // Signed operands are reduced to magnitudes; the sign is reapplied once in SIGN.
   // The most-negative value negates to itself, which read unsigned is 2^(WIDTH-1).
   assign abs_a = (iSigned && iA[WIDTH-1]) ? (~iA + WIDTH'(1)) : iA;
   assign abs_b = (iSigned && iB[WIDTH-1]) ? (~iB + WIDTH'(1)) : iB;

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         acc_q    <= '0;
         result_q <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         mcand_q  <= mcand_d;
         acc_q    <= acc_d;
         result_q <= result_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         neg_q    <= neg_d;
         done_q   <= done_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      mcand_d  = mcand_q;
      acc_d    = acc_q;
      result_d = result_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      neg_d    = neg_q;
      done_d   = 1'b0;
      busy     = 1'b0;
      case (state_q)
         IDLE: begin
            if (iStart) begin
               mcand_d  = {{WIDTH{1'b0}}, abs_a};
               mplier_d = abs_b;
               neg_d    = iSigned & (iA[WIDTH-1] ^ iB[WIDTH-1]);
               acc_d    = '0;
               cnt_d    = '0;
               state_d  = CALC;
            end
         end
         CALC: begin
            busy = 1'b1;
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(WIDTH - 1)) begin
               state_d = SIGN;
            end
         end
         SIGN: begin
            busy     = 1'b1;
            result_d = neg_q ? (~acc_q + (2*WIDTH)'(1)) : acc_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign oBusy   = busy;
   assign oDone   = done_q;
   assign oResult = result_q;
endmodule

// File: tb/tb_seq_imul.sv
// Bench for seq_imul at WIDTH=4 and WIDTH=8; results are checked through per-DUT expectation queues.
module tb_seq_imul;
   logic        Clock;
   logic        Reset_n;
   logic        start4, signed4, busy4, done4;
   logic [3:0]  a4, b4;
   logic [7:0]  res4;
   logic        start8, signed8, busy8, done8;
   logic [7:0]  a8, b8;
   logic [15:0] res8;

   int checks = 0;
   int errors = 0;
   logic [7:0]  q4[$];
   logic [15:0] q8[$];

   seq_imul #(.WIDTH(4)) dut4 (
      .Clock(Clock), .Reset_n(Reset_n), .iStart(start4), .iSigned(signed4),
      .iA(a4), .iB(b4), .oBusy(busy4), .oDone(done4), .oResult(res4)
   );

   seq_imul #(.WIDTH(8)) dut8 (
      .Clock(Clock), .Reset_n(Reset_n), .iStart(start8), .iSigned(signed8),
      .iA(a8), .iB(b8), .oBusy(busy8), .oDone(done8), .oResult(res8)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   // Plain integer multiply, then wrap to 2*w bits.
   function automatic logic [15:0] ref_mul(input int a, input int b, input bit s, input int w);
      longint sa, sb, p;
      sa = a;
      sb = b;
      if (s) begin
         if (a >= (1 << (w - 1))) sa = a - (1 << w);
         if (b >= (1 << (w - 1))) sb = b - (1 << w);
      end
      p = sa * sb;
      return 16'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   always @(negedge Clock) begin
      if (done4 === 1'b1) begin
         logic [7:0] exp4;
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL w4_unexpected_done: result=%h with nothing outstanding", res4);
         end else begin
            exp4 = q4.pop_front();
            if (res4 !== exp4) begin
               errors++;
               $display("FAIL w4_result: got %h expected %h", res4, exp4);
            end
         end
      end
      if (done8 === 1'b1) begin
         logic [15:0] exp8;
         checks++;
         if (q8.size() == 0) begin
            errors++;
            $display("FAIL w8_unexpected_done: result=%h with nothing outstanding", res8);
         end else begin
            exp8 = q8.pop_front();
            if (res8 !== exp8) begin
               errors++;
               $display("FAIL w8_result: got %h expected %h", res8, exp8);
            end
         end
      end
   end

   task automatic issue4(input logic [3:0] a, input logic [3:0] b, input logic s);
      logic [15:0] r;
      @(negedge Clock);
      a4 = a; b4 = b; signed4 = s; start4 = 1'b1;
      r = ref_mul(a, b, s, 4);
      q4.push_back(r[7:0]);
      @(posedge Clock);
      #1;
      start4 = 1'b0;
      a4 = 4'($urandom); b4 = 4'($urandom); signed4 = 1'($urandom);
   endtask

   task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic s);
      @(negedge Clock);
      a8 = a; b8 = b; signed8 = s; start8 = 1'b1;
      q8.push_back(ref_mul(a, b, s, 8));
      @(posedge Clock);
      #1;
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); signed8 = 1'($urandom);
   endtask

   // Counts negedges after the start edge up to and including the oDone cycle.
   task automatic wait_done(input bit which, output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      while (!seen && n < 40) begin
         @(negedge Clock);
         n++;
         if ((which ? done8 : done4) === 1'b1) seen = 1'b1;
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: no oDone within %0d cycles", n);
      end
   endtask

   task automatic test_reset();
      Reset_n = 1'b0;
      start4 = 1'b0; signed4 = 1'b0; a4 = '0; b4 = '0;
      start8 = 1'b0; signed8 = 1'b0; a8 = '0; b8 = '0;
      #12;
      checks++;
      if ({busy4, done4, res4} !== 10'd0) begin
         errors++;
         $display("FAIL reset_w4: busy=%b done=%b result=%h, need all 0", busy4, done4, res4);
      end
      checks++;
      if ({busy8, done8, res8} !== 18'd0) begin
         errors++;
         $display("FAIL reset_w8: busy=%b done=%b result=%h, need all 0", busy8, done8, res8);
      end
      @(posedge Clock);
      #1;
      Reset_n = 1'b1;
   endtask

   task automatic test_idle();
      for (int i = 0; i < 20; i++) begin
         @(negedge Clock);
         checks++;
         if ({busy4, done4, res4} !== 10'd0) begin
            errors++;
            $display("FAIL idle_cycle%0d: busy=%b done=%b result=%h, need all 0", i, busy4, done4, res4);
         end
      end
   endtask

   task automatic test_unsigned_max();
      issue4(4'd15, 4'd15, 1'b0);
      for (int i = 1; i <= 5; i++) begin
         @(negedge Clock);
         checks++;
         if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL umax_busy_cycle%0d: busy=%b done=%b, need busy=1 done=0", i, busy4, done4);
         end
      end
      @(negedge Clock);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b1) begin
         errors++;
         $display("FAIL umax_done_cycle: busy=%b done=%b, need busy=0 done=1", busy4, done4);
      end
      @(negedge Clock);
      checks++;
      if (done4 !== 1'b0 || res4 !== 8'hE1) begin
         errors++;
         $display("FAIL umax_after_done: done=%b result=%h, need done=0 result=e1", done4, res4);
      end
   endtask

   task automatic test_signed_corners();
      logic [3:0] ta[4] = '{4'hD, 4'h8, 4'h8, 4'h0};
      logic [3:0] tb[4] = '{4'h5, 4'h8, 4'h7, 4'hF};
      int n;
      for (int i = 0; i < 4; i++) begin
         issue4(ta[i], tb[i], 1'b1);
         wait_done(1'b0, n);
         checks++;
         if (n !== 6) begin
            errors++;
            $display("FAIL signed_latency%0d: got %0d cycles, need 6", i, n);
         end
      end
   endtask

   task automatic test_sweep();
      int n;
      for (int s = 0; s < 2; s++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               issue4(4'(a), 4'(b), s[0]);
               wait_done(1'b0, n);
               checks++;
               if (n !== 6) begin
                  errors++;
                  $display("FAIL sweep_latency s=%0d a=%0d b=%0d: got %0d, need 6", s, a, b, n);
               end
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      int n;
      @(negedge Clock);
      a4 = 4'd3; b4 = 4'd5; signed4 = 1'b0; start4 = 1'b1;
      q4.push_back(8'd15);
      for (int i = 1; i <= 5; i++) begin
         @(negedge Clock);
         checks++;
         if (busy4 !== 1'b1 || done4 !== 1'b0) begin
            errors++;
            $display("FAIL hold_busy_cycle%0d: busy=%b done=%b, need busy=1 done=0", i, busy4, done4);
         end
         a4 = 4'($urandom); b4 = 4'($urandom); signed4 = 1'($urandom);
      end
      @(negedge Clock);
      checks++;
      if (done4 !== 1'b1) begin
         errors++;
         $display("FAIL hold_done: done=%b, need 1", done4);
      end
      a4 = 4'd9; b4 = 4'd11; signed4 = 1'b0;
      q4.push_back(8'd99);
      @(posedge Clock);
      #1;
      start4 = 1'b0;
      wait_done(1'b0, n);
      checks++;
      if (n !== 6) begin
         errors++;
         $display("FAIL b2b_latency: got %0d cycles, need 6", n);
      end
   endtask

   task automatic test_abort();
      int n;
      issue4(4'd13, 4'd11, 1'b0);
      repeat (3) @(negedge Clock);
      #1;
      Reset_n = 1'b0;
      #1;
      q4.delete();
      checks++;
      if ({busy4, done4, res4} !== 10'd0) begin
         errors++;
         $display("FAIL abort_async: busy=%b done=%b result=%h, need all 0", busy4, done4, res4);
      end
      #1;
      Reset_n = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge Clock);
         checks++;
         if (done4 !== 1'b0 || busy4 !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet%0d: busy=%b done=%b, need 0", i, busy4, done4);
         end
      end
      issue4(4'd6, 4'd7, 1'b0);
      wait_done(1'b0, n);
      checks++;
      if (res4 !== 8'h2A) begin
         errors++;
         $display("FAIL abort_recover: result=%h, need 2a", res4);
      end
   endtask

   task automatic test_width8();
      logic [7:0] ta[3] = '{8'hFF, 8'h80, 8'h80};
      logic [7:0] tb[3] = '{8'hFF, 8'h7F, 8'h80};
      logic       ts[3] = '{1'b0, 1'b1, 1'b1};
      int n;
      for (int i = 0; i < 3; i++) begin
         issue8(ta[i], tb[i], ts[i]);
         wait_done(1'b1, n);
         checks++;
         if (n !== 10) begin
            errors++;
            $display("FAIL w8_latency%0d: got %0d cycles, need 10", i, n);
         end
      end
      checks++;
      if (res8 !== 16'h4000) begin
         errors++;
         $display("FAIL w8_hold: result=%h, need 4000", res8);
      end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_unsigned_max();
      test_signed_corners();
      test_sweep();
      test_back_to_back();
      test_abort();
      test_width8();
      repeat (3) @(negedge Clock);
      checks++;
      if (q4.size() != 0 || q8.size() != 0) begin
         errors++;
         $display("FAIL outstanding: w4=%0d w8=%0d results never produced, need 0", q4.size(), q8.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
